note_select_ctrl: RTL
=====================

// Module: note_select_ctrl
// PURPOSE
//   Player-input front end for the guitar tone generator. Debounces seven raw fret buttons (notes A..G) and a strum button.
//   On each strum, latches the selected note as a 3-bit code and gates it for a sustain time.
//   note_code drives the tone generator's note-select input; note_gate enables/mutes its square-wave output.
// PARAMETERS
//   DEBOUNCE_CYCLES  250_000     clk cycles an input must hold its new level before the change is accepted (10 ms @ 25 MHz); >=1
//   SUSTAIN_CYCLES   25_000_000  clk cycles note_gate stays high after a strum (1 s @ 25 MHz); >=1
//   OPEN_NOTE        3'd4        code output when strummed with no fret pressed (E, open string)
// PORTS
//   clk          in   1  system clock, 25 MHz
//   rst_n        in   1  asynchronous, active-low reset
//   fret_btn     in   7  raw asynchronous fret buttons; bit i = note code i (0=A .. 6=G), 1 = pressed
//   strum_btn    in   1  raw asynchronous strum button, 1 = pressed
//   note_code    out  3  selected note code, registered
//   note_gate    out  1  1 while the note sounds
//   note_trig    out  1  one-cycle pulse on each new note latch
// BEHAVIOUR
//   Reset (async assert, sync release): note_code=OPEN_NOTE, note_gate=0, note_trig=0, FSM=IDLE; all debounced levels=0; counters=0.
//     Reset mid-note mutes on the same edge.
//   Input conditioning, per button:
//     - 2-FF synchroniser.
//     - Debounced level toggles only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles.
//     - Any sample equal to the current level clears the counter.
//   Fret encode (combinational on debounced frets): highest set index wins (G over A); no fret -> OPEN_NOTE.
//   Strum event: rising edge of the debounced strum (1 cycle). Holding strum never re-triggers; a release must debounce first.
//   FSM states: IDLE, SOUNDING.
//     IDLE -strum-> SOUNDING: note_code<=encode, note_gate<=1, note_trig<=1, sustain counter<=SUSTAIN_CYCLES-1.
//     SOUNDING -strum-> SOUNDING: re-latch note_code, pulse note_trig, reload counter (re-strum of the same note also pulses).
//     SOUNDING, counter==0, no strum -> IDLE: note_gate<=0; note_code holds its last value.
//     SOUNDING otherwise: counter decrements.
//     Strum in the same cycle as expiry: strum wins, stays SOUNDING, counter reloads.
//   Timing:
//     - note_gate is high for exactly SUSTAIN_CYCLES cycles per strum with no re-strum.
//     - Latency from the debounced strum edge to outputs: 1 cycle.
//     - Latency from a clean raw press: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//   Widths: counters are $clog2(param+1) bits, no wrap; frets not sampled outside strum events (unless legato is enabled).
// CONFIGURATION
//   NOTE_LEGATO_EN defined:
//     - In SOUNDING, a change in the encoded fret value (incl. fall to OPEN_NOTE on all-release) updates note_code next cycle.
//     - Pulses note_trig; sustain counter NOT reloaded (hammer-on / pull-off).
//     - If that change coincides with a strum, the strum rules apply.
//   NOTE_LEGATO_EN undefined: note_code changes only on strum events.
// STRUCTURE
//   Package note_pkg:
//     - NOTE_W=3; localparams NOTE_A..NOTE_G = 3'd0..3'd6.
//     - FSM state typedef {IDLE, SOUNDING}; shared with the tone generator.
//   Sub-module btn_debounce:
//     - Parameter CYCLES; ports clk, rst_n, raw, level, rise.
//     - 2-FF sync + stability counter; instantiated 8 times (7 frets, 1 strum).
//   Top level holds the priority encoder, strum/expiry FSM, sustain counter and output registers.
// TESTING  (DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=20)
//   1. Reset with rst_n=0 mid-SOUNDING -> note_gate=0, note_code=3'd4, note_trig=0 immediately, without waiting for clk.
//   2. fret_btn=7'b0000100, strum held 10 cycles -> note_code=3'd2, gate high exactly 20 cycles, one note_trig pulse; strum release gives no pulse.
//   3. Strum glitch 1,0,1,0 (3 cycles per level, <4) -> no note_trig, gate stays 0.
//   4. fret_btn=7'b1000001, strum -> note_code=3'd6; no fret, strum -> 3'd4.
//   5. Re-strum at gate cycle 15, and separately in the expiry cycle -> gate stays high 20 more cycles; note_trig pulses both times.
//   6. Fret 3'd0 strummed, then fret changed to 3'd3 while SOUNDING:
//      - NOTE_LEGATO_EN -> note_code=3'd3 after debounce+sync+1, note_trig pulse, gate end unchanged.
//      - Without it -> note_code stays 3'd0.

Source files
------------

// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg
//   Shared definitions for the guitar note front end and the tone generator.
//   - NOTE_W and the note codes A..G (0..6)
//   - noteState_t : FSM state type (IDLE / SOUNDING), also used downstream
//   - encodeFrets : highest pressed fret wins, no fret gives the open note
// ---------------------------------------------------------------------------
package note_pkg;

   localparam int NOTE_W = 3;

   localparam logic [NOTE_W-1:0] NOTE_A = 3'd0;
   localparam logic [NOTE_W-1:0] NOTE_B = 3'd1;
   localparam logic [NOTE_W-1:0] NOTE_C = 3'd2;
   localparam logic [NOTE_W-1:0] NOTE_D = 3'd3;
   localparam logic [NOTE_W-1:0] NOTE_E = 3'd4;
   localparam logic [NOTE_W-1:0] NOTE_F = 3'd5;
   localparam logic [NOTE_W-1:0] NOTE_G = 3'd6;

   typedef enum logic {
      IDLE     = 1'b0,
      SOUNDING = 1'b1
   } noteState_t;

   // Ascending scan so the highest set index is the one left standing.
   function automatic logic [NOTE_W-1:0] encodeFrets(
      input logic [6:0]        frets,
      input logic [NOTE_W-1:0] openNote
   );
      logic [NOTE_W-1:0] code;
      code = openNote;
      for (int i = 0; i < 7; i++) begin
         if (frets[i]) begin
            code = NOTE_W'(i);
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser followed by a stability counter. The debounced
//   level only flips once the synchronised input has disagreed with it for
//   CYCLES consecutive clocks; any agreeing sample restarts the count.
// Parameters
//   CYCLES : consecutive disagreeing samples needed to accept a change (>=1)
// Ports
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   raw   in  raw asynchronous button input
//   level out debounced level
//   rise  out one-cycle pulse, registered with the 0->1 change of level
// ---------------------------------------------------------------------------
module btn_debounce #(
   parameter int CYCLES = 250_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   logic             syncMeta;
   logic             syncOut;
   logic [CNT_W-1:0] stableCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncMeta  <= 1'b0;
         syncOut   <= 1'b0;
         stableCnt <= '0;
         level     <= 1'b0;
         rise      <= 1'b0;
      end else begin
         syncMeta <= raw;
         syncOut  <= syncMeta;
         rise     <= 1'b0;
         if (syncOut == level) begin
            stableCnt <= '0;
         end else if (stableCnt == CNT_LAST) begin
            // This sample is the CYCLES-th disagreeing one: accept it.
            level     <= syncOut;
            rise      <= syncOut;
            stableCnt <= '0;
         end else begin
            stableCnt <= stableCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/note_select_ctrl.sv
// ---------------------------------------------------------------------------
// note_select_ctrl
//   Player-input front end for the guitar tone generator. Debounces seven
//   fret buttons and a strum button; each strum latches the encoded fret as
//   a note code and opens the gate for SUSTAIN_CYCLES clocks.
// Build option
//   NOTE_LEGATO_EN : while sounding, a change of the encoded fret re-latches
//                    note_code and pulses note_trig without reloading the
//                    sustain time (hammer-on / pull-off).
// Parameters
//   DEBOUNCE_CYCLES : clocks a button must hold a new level (>=1)
//   SUSTAIN_CYCLES  : clocks note_gate stays high per strum (>=1)
//   OPEN_NOTE       : code latched when strummed with no fret pressed
// Ports
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   fret_btn  in  raw fret buttons, bit i = note code i, 1 = pressed
//   strum_btn in  raw strum button, 1 = pressed
//   note_code out selected note code (registered)
//   note_gate out high while the note sounds
//   note_trig out one-cycle pulse on every new note latch
// ---------------------------------------------------------------------------
module note_select_ctrl
   import note_pkg::*;
#(
   parameter int                DEBOUNCE_CYCLES = 250_000,
   parameter int                SUSTAIN_CYCLES  = 25_000_000,
   parameter logic [NOTE_W-1:0] OPEN_NOTE       = NOTE_E
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        fret_btn,
   input  logic              strum_btn,
   output logic [NOTE_W-1:0] note_code,
   output logic              note_gate,
   output logic              note_trig
);

   localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);
   localparam logic [SUS_W-1:0] SUS_LOAD = SUS_W'(SUSTAIN_CYCLES - 1);

   logic [6:0]        fretLevel;
   logic [6:0]        unusedFretRise;
   logic              unusedStrumLevel;
   logic              strumRise;
   logic [NOTE_W-1:0] fretEnc;

   noteState_t        state;
   noteState_t        stateNext;
   logic [SUS_W-1:0]  sustainCnt;
   logic [SUS_W-1:0]  sustainCntNext;
   logic [NOTE_W-1:0] codeReg;
   logic [NOTE_W-1:0] codeNext;
   logic              trigReg;
   logic              trigNext;
`ifdef NOTE_LEGATO_EN
   logic [NOTE_W-1:0] encPrev;
`endif

   // ---------------- input conditioning ----------------
   generate
      for (genvar gi = 0; gi < 7; gi++) begin : gFret
         btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) uFretDb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (fret_btn[gi]),
            .level (fretLevel[gi]),
            .rise  (unusedFretRise[gi])
         );
      end
   endgenerate

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) uStrumDb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (strum_btn),
      .level (unusedStrumLevel),
      .rise  (strumRise)
   );

   assign fretEnc = encodeFrets(fretLevel, OPEN_NOTE);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sustainCnt <= '0;
         codeReg    <= OPEN_NOTE;
         trigReg    <= 1'b0;
`ifdef NOTE_LEGATO_EN
         encPrev    <= OPEN_NOTE;
`endif
      end else begin
         state      <= stateNext;
         sustainCnt <= sustainCntNext;
         codeReg    <= codeNext;
         trigReg    <= trigNext;
`ifdef NOTE_LEGATO_EN
         encPrev    <= fretEnc;
`endif
      end
   end

   // ---------------- next-state logic ----------------
   // A strum takes priority over everything, including the expiry cycle,
   // so a re-strum on the last gate clock extends the note seamlessly.
   always_comb begin
      stateNext      = state;
      sustainCntNext = sustainCnt;
      codeNext       = codeReg;
      trigNext       = 1'b0;
      if (strumRise) begin
         stateNext      = SOUNDING;
         sustainCntNext = SUS_LOAD;
         codeNext       = fretEnc;
         trigNext       = 1'b1;
      end else if (state == SOUNDING) begin
         if (sustainCnt == '0) begin
            stateNext = IDLE;
         end else begin
            sustainCntNext = sustainCnt - SUS_W'(1);
`ifdef NOTE_LEGATO_EN
            if (fretEnc != encPrev) begin
               codeNext = fretEnc;
               trigNext = 1'b1;
            end
`endif
         end
      end
   end

   // ---------------- outputs ----------------
   // Gate decodes the state register directly, so an asynchronous reset
   // mutes the note without waiting for a clock.
   always_comb begin
      note_code = codeReg;
      note_trig = trigReg;
      note_gate = (state == SOUNDING);
   end

endmodule
